// File: rtl/alu_mdu_pkg.sv
// Shared definitions for the handshaked ALU / multiply-divide unit.
// Op encodings, FSM states and op-class predicates.
package alu_mdu_pkg;

    localparam int W_DEFAULT = 32;

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_AND    = 5'd2;
    localparam logic [4:0] OP_OR     = 5'd3;
    localparam logic [4:0] OP_XOR    = 5'd4;
    localparam logic [4:0] OP_SLT    = 5'd5;
    localparam logic [4:0] OP_SLTU   = 5'd6;
    localparam logic [4:0] OP_SLL    = 5'd7;
    localparam logic [4:0] OP_SRL    = 5'd8;
    localparam logic [4:0] OP_SRA    = 5'd9;
    localparam logic [4:0] OP_COPY1  = 5'd10;

    localparam logic [4:0] OP_MUL    = 5'd16;
    localparam logic [4:0] OP_MULH   = 5'd17;
    localparam logic [4:0] OP_MULHSU = 5'd18;
    localparam logic [4:0] OP_MULHU  = 5'd19;
    localparam logic [4:0] OP_DIV    = 5'd20;
    localparam logic [4:0] OP_DIVU   = 5'd21;
    localparam logic [4:0] OP_REM    = 5'd22;
    localparam logic [4:0] OP_REMU   = 5'd23;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_e;

    // M ops occupy codes 16..23, divides 20..23.
    function automatic logic is_mop(input logic [4:0] op);
        return op[4:3] == 2'b10;
    endfunction

    function automatic logic is_div(input logic [4:0] op);
        return op[4:2] == 3'b101;
    endfunction

endpackage

// File: rtl/alu_mdu_iter.sv
// Iterative multiply / restoring divide engine: one step per cycle on magnitudes,
// sign correction and special-case overrides applied on the final result.
module alu_mdu_iter
    import alu_mdu_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [4:0]   op,
    input  logic [W-1:0] op1,
    input  logic [W-1:0] op2,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result
);

    localparam int CW = $clog2(W);

    logic [2*W-1:0] acc_q, acc_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   op1_q, op1_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic           div_q, div_d;
    logic           neg_q, neg_d;
    logic           rneg_q, rneg_d;
    logic           hi_q, hi_d;
    logic           div0_q, div0_d;
    logic           ovf_q, ovf_d;

    logic           s1, s2;
    logic [W-1:0]   mag1, mag2;
    logic [W:0]     mul_sum;
    logic [W+1:0]   div_diff;
    logic [2*W-1:0] prod;
    logic [W-1:0]   quo, rem;

    // Multiply keeps the multiplier in the low half and shifts right;
    // divide keeps the dividend in the low half and shifts left, quotient bits entering at bit 0.
    always_comb begin
        s1       = op1[W-1] && (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM);
        s2       = op2[W-1] && (op == OP_MULH || op == OP_DIV || op == OP_REM);
        mag1     = s1 ? -op1 : op1;
        mag2     = s2 ? -op2 : op2;
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : {(W+1){1'b0}});
        div_diff = {1'b0, acc_q[2*W-1:W-1]} - {2'b00, b_q};

        acc_d  = acc_q;
        b_d    = b_q;
        op1_d  = op1_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        div_d  = div_q;
        neg_d  = neg_q;
        rneg_d = rneg_q;
        hi_d   = hi_q;
        div0_d = div0_q;
        ovf_d  = ovf_q;

        if (start) begin
            busy_d = 1'b1;
            cnt_d  = CW'(W - 1);
            div_d  = is_div(op);
            neg_d  = s1 ^ s2;
            rneg_d = s1;
            hi_d   = is_div(op) ? (op == OP_REM || op == OP_REMU) : (op != OP_MUL);
            div0_d = is_div(op) && (op2 == '0);
            ovf_d  = (op == OP_DIV || op == OP_REM) && (op1 == {1'b1, {(W-1){1'b0}}}) && (op2 == '1);
            op1_d  = op1;
            b_d    = is_div(op) ? mag2 : mag1;
            acc_d  = {{W{1'b0}}, (is_div(op) ? mag1 : mag2)};
        end else if (busy_q) begin
            if (div_q) begin
                acc_d = div_diff[W+1] ? {acc_q[2*W-2:0], 1'b0}
                                      : {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
            end else begin
                acc_d = {mul_sum, acc_q[W-1:1]};
            end
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_comb begin
        prod = neg_q ? -acc_q : acc_q;
        quo  = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
        rem  = rneg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
        if (div0_q) begin
            quo = '1;
            rem = op1_q;
        end else if (ovf_q) begin
            quo = op1_q;
            rem = '0;
        end
        if (div_q) begin
            result = hi_q ? rem : quo;
        end else begin
            result = hi_q ? prod[2*W-1:W] : prod[W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            b_q    <= '0;
            op1_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            hi_q   <= 1'b0;
            div0_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            b_q    <= b_d;
            op1_q  <= op1_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            div_q  <= div_d;
            neg_q  <= neg_d;
            rneg_q <= rneg_d;
            hi_q   <= hi_d;
            div0_q <= div0_d;
            ovf_q  <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == '0);

endmodule

// File: rtl/alu_mdu_seq.sv
// Handshaked RV32I ALU with iterative M-extension ops; base ops complete in one
// cycle, M ops take a fixed W+2 cycles through the alu_mdu_iter engine.
module alu_mdu_seq
    import alu_mdu_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [4:0]   op,
    input  logic [W-1:0] op1,
    input  logic [W-1:0] op2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result
);

    localparam int SHW = $clog2(W);

    state_e         state_q, state_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   result_q, result_d;
    logic [W-1:0]   base_res;
    logic [SHW-1:0] shamt;
    logic           accept;
    logic           iter_start, iter_busy, iter_done;
    logic [W-1:0]   iter_result;

    assign shamt    = op2[SHW-1:0];
    assign in_ready = (state_q == IDLE) || (state_q == DONE && out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        base_res = '0;
        case (op)
            OP_ADD:   base_res = op1 + op2;
            OP_SUB:   base_res = op1 - op2;
            OP_AND:   base_res = op1 & op2;
            OP_OR:    base_res = op1 | op2;
            OP_XOR:   base_res = op1 ^ op2;
            OP_SLT:   base_res = {{(W-1){1'b0}}, ($signed(op1) < $signed(op2))};
            OP_SLTU:  base_res = {{(W-1){1'b0}}, (op1 < op2)};
            OP_SLL:   base_res = op1 << shamt;
            OP_SRL:   base_res = op1 >> shamt;
            OP_SRA:   base_res = $signed(op1) >>> shamt;
            OP_COPY1: base_res = op1;
            default:  base_res = '0;
        endcase
    end

    alu_mdu_iter #(
        .W(W)
    ) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (iter_start),
        .op     (op),
        .op1    (op1),
        .op2    (op2),
        .busy   (iter_busy),
        .done   (iter_done),
        .result (iter_result)
    );

    // DONE with out_ready behaves like IDLE so a new op can be taken in the transfer cycle.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        iter_start  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE && out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
                if (accept) begin
                    if (is_mop(op)) begin
                        state_d     = CALC;
                        out_valid_d = 1'b0;
                        iter_start  = 1'b1;
                    end else begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        result_d    = base_res;
                    end
                end
            end
            CALC: begin
                if (iter_done) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (!iter_busy) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    result_d    = iter_result;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Scoreboard bench for alu_mdu_seq: expected results queued at accept, compared at transfer.
module tb_alu_mdu_seq;

    localparam int W = 32;

    localparam logic [4:0] T_ADD = 5'd0,  T_SUB = 5'd1,  T_XOR = 5'd4,  T_SLT = 5'd5;
    localparam logic [4:0] T_SRA = 5'd9,  T_MUL = 5'd16, T_MULH = 5'd17, T_MULHSU = 5'd18;
    localparam logic [4:0] T_MULHU = 5'd19, T_DIV = 5'd20, T_DIVU = 5'd21, T_REM = 5'd22, T_REMU = 5'd23;
    localparam logic [W-1:0] MIN_INT = 32'h8000_0000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [4:0]   op = '0;
    logic [W-1:0] op1 = '0;
    logic [W-1:0] op2 = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;

    logic [W-1:0] exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_mdu_seq #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .op1       (op1),
        .op2       (op2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] base_model(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (o)
            5'd0:    return a + b;
            5'd1:    return a - b;
            5'd2:    return a & b;
            5'd3:    return a | b;
            5'd4:    return a ^ b;
            5'd5:    return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            5'd6:    return (a < b) ? W'(1) : W'(0);
            5'd7:    return a << sh;
            5'd8:    return a >> sh;
            5'd9:    return W'($signed(a) >>> sh);
            5'd10:   return a;
            default: return '0;
        endcase
    endfunction

    function automatic logic [W-1:0] mdu_model(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] ea, eb, p;
        logic           ovf;
        ea  = {{W{(o == T_MULH || o == T_MULHSU) && a[W-1]}}, a};
        eb  = {{W{(o == T_MULH) && b[W-1]}}, b};
        p   = ea * eb;
        ovf = (a == MIN_INT) && (b == '1);
        case (o)
            T_MUL:  return p[W-1:0];
            T_DIV:  return (b == '0) ? '1 : (ovf ? a : W'($signed(a) / $signed(b)));
            T_DIVU: return (b == '0) ? '1 : a / b;
            T_REM:  return (b == '0) ? a : (ovf ? '0 : W'($signed(a) % $signed(b)));
            T_REMU: return (b == '0) ? a : a % b;
            default: return p[2*W-1:W];
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        vectors++;
        if (result !== '0) begin miscompares++; $display("[TB] FAIL reset_result: got %h expected 0", result); end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        rst = 1'b0;
        step();
    endtask

    // Drives a list of base ops back to back with in_valid held; each result is due one cycle after accept.
    task automatic run_base_stream(input string name, input logic [4:0] ops[$], input logic [W-1:0] as[$], input logic [W-1:0] bs[$], input logic [W-1:0] exps[$]);
        logic [W-1:0] e;
        out_ready = 1'b1;
        for (int i = 0; i < ops.size(); i++) begin
            in_valid = 1'b1;
            op  = ops[i];
            op1 = as[i];
            op2 = bs[i];
            #1;
            vectors++;
            if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL %s_in_ready[%0d]: got %b expected 1", name, i, in_ready); end
            exp_q.push_back(exps[i]);
            step();
            e = exp_q.pop_front();
            vectors++;
            if (out_valid !== 1'b1 || result !== e) begin
                miscompares++;
                $display("[TB] FAIL %s[%0d] op=%0d: got valid=%b result=%h expected valid=1 result=%h", name, i, ops[i], out_valid, result, e);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_base_back_to_back();
        logic [4:0]   ops[$]  = '{T_ADD, T_SRA, T_SLT};
        logic [W-1:0] as[$]   = '{32'd5, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [W-1:0] bs[$]   = '{32'd7, 32'd4, 32'd1};
        logic [W-1:0] exps[$] = '{32'd12, 32'hF800_0000, 32'd1};
        run_base_stream("base_b2b", ops, as, bs, exps);
    endtask

    task automatic test_illegal();
        logic [4:0]   ops[$]  = '{T_ADD, 5'd12, 5'd31, 5'd11};
        logic [W-1:0] as[$]   = '{32'd5, 32'h1234_5678, 32'hFFFF_FFFF, 32'hA5A5_A5A5};
        logic [W-1:0] bs[$]   = '{32'd7, 32'h55, 32'hFFFF_FFFF, 32'd3};
        logic [W-1:0] exps[$] = '{32'd12, 32'd0, 32'd0, 32'd0};
        run_base_stream("illegal", ops, as, bs, exps);
    endtask

    task automatic test_base_random();
        logic [4:0]   ops[$];
        logic [W-1:0] as[$], bs[$], exps[$];
        logic [4:0]   o;
        logic [W-1:0] a, b;
        for (int i = 0; i < 24; i++) begin
            o = 5'($urandom_range(0, 10));
            a = $urandom;
            b = (i % 3 == 0) ? a : $urandom;
            ops.push_back(o);
            as.push_back(a);
            bs.push_back(b);
            exps.push_back(base_model(o, a, b));
        end
        run_base_stream("base_rand", ops, as, bs, exps);
    endtask

    // Issues one M op, toggles junk inputs while busy and checks latency, in_ready and result.
    task automatic run_mdu(input string name, input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] e_in);
        logic [W-1:0] e;
        int lat, busy_bad;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op  = o;
        op1 = a;
        op2 = b;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL %s_accept op=%0d: got in_ready=%b expected 1", name, o, in_ready); end
        exp_q.push_back(e_in);
        step();
        lat = 1;
        busy_bad = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            if (in_ready !== 1'b0) busy_bad++;
            op  = 5'($urandom_range(0, 31));
            op1 = $urandom;
            op2 = $urandom;
            step();
            lat++;
        end
        in_valid = 1'b0;
        e = exp_q.pop_front();
        vectors++;
        if (lat != W + 2) begin miscompares++; $display("[TB] FAIL %s_latency op=%0d: got %0d expected %0d", name, o, lat, W + 2); end
        vectors++;
        if (busy_bad != 0) begin miscompares++; $display("[TB] FAIL %s_busy_in_ready op=%0d: got %0d busy cycles ready expected 0", name, o, busy_bad); end
        vectors++;
        if (result !== e) begin miscompares++; $display("[TB] FAIL %s_result op=%0d a=%h b=%h: got %h expected %h", name, o, a, b, result, e); end
        step();
    endtask

    task automatic test_mdu_corners();
        logic [4:0]   ops[10] = '{T_MUL, T_MULH, T_MULHU, T_MULHSU, T_DIV, T_REM, T_DIVU, T_REMU, T_DIV, T_REM};
        logic [W-1:0] as[10]  = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                                  32'hFFFF_FFF9, 32'd9, 32'd9, MIN_INT, MIN_INT};
        logic [W-1:0] bs[10]  = '{32'd3, 32'd3, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0,
                                  32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [W-1:0] ex[10]  = '{32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                                  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd9, MIN_INT, 32'd0};
        for (int i = 0; i < 10; i++) begin
            run_mdu("mdu_corner", ops[i], as[i], bs[i], ex[i]);
        end
    endtask

    task automatic test_mdu_random();
        logic [4:0]   o;
        logic [W-1:0] a, b;
        for (int i = 0; i < 12; i++) begin
            o = 5'(16 + $urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 4))
                0: b = '0;
                1: begin a = MIN_INT; b = '1; end
                2: b = W'($urandom_range(1, 15));
                default: ;
            endcase
            run_mdu("mdu_rand", o, a, b, mdu_model(o, a, b));
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] e;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op  = T_XOR;
        op1 = 32'h0000_F0F0;
        op2 = 32'h0000_0FF0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_accept: got in_ready=%b expected 1", in_ready); end
        exp_q.push_back(32'h0000_FF00);
        step();
        op  = T_SUB;
        op2 = 32'd5;
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (out_valid !== 1'b1 || result !== exp_q[0] || in_ready !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL bp_hold[%0d]: got valid=%b result=%h in_ready=%b expected valid=1 result=%h in_ready=0",
                         k, out_valid, result, in_ready, exp_q[0]);
            end
            op1 = $urandom;
            step();
        end
        out_ready = 1'b1;
        op1 = 32'd3;
        #1;
        e = exp_q.pop_front();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || result !== e) begin
            miscompares++;
            $display("[TB] FAIL bp_release: got in_ready=%b valid=%b result=%h expected in_ready=1 valid=1 result=%h", in_ready, out_valid, result, e);
        end
        exp_q.push_back(32'hFFFF_FFFE);
        step();
        in_valid = 1'b0;
        e = exp_q.pop_front();
        vectors++;
        if (out_valid !== 1'b1 || result !== e) begin
            miscompares++;
            $display("[TB] FAIL bp_next_op: got valid=%b result=%h expected valid=1 result=%h", out_valid, result, e);
        end
        step();
    endtask

    task automatic test_reset_midop();
        logic [W-1:0] e;
        int stale;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op  = T_DIVU;
        op1 = 32'd1000;
        op2 = 32'd7;
        #1;
        step();
        in_valid = 1'b0;
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0) begin
            miscompares++;
            $display("[TB] FAIL midop_reset: got valid=%b in_ready=%b result=%h expected valid=0 in_ready=1 result=0", out_valid, in_ready, result);
        end
        in_valid = 1'b1;
        op  = T_ADD;
        op1 = 32'd1;
        op2 = 32'd1;
        #1;
        exp_q.push_back(32'd2);
        step();
        in_valid = 1'b0;
        e = exp_q.pop_front();
        vectors++;
        if (out_valid !== 1'b1 || result !== e) begin
            miscompares++;
            $display("[TB] FAIL midop_add: got valid=%b result=%h expected valid=1 result=%h", out_valid, result, e);
        end
        step();
        stale = 0;
        repeat (W + 8) begin
            if (out_valid !== 1'b0) stale++;
            step();
        end
        vectors++;
        if (stale != 0) begin miscompares++; $display("[TB] FAIL midop_stale: got %0d valid cycles expected 0", stale); end
    endtask

    initial begin
        test_reset();
        test_base_back_to_back();
        test_illegal();
        test_base_random();
        test_mdu_corners();
        test_mdu_random();
        test_backpressure();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
